// File: rtl/mont_operand_prep.sv
// Operand front-end for the Montgomery datapath: latches operands, builds the
// k*b and (j+1)*m multiple tables on one shared adder, then launches the datapath.
module mont_operand_prep #(
  parameter int unsigned NBITS  = 2048,
  parameter int unsigned PBITS  = 1,
  parameter int unsigned MLSIZE = 1 << PBITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_p,
  input  logic [NBITS-1:0]           a_in,
  input  logic [NBITS-1:0]           b_in,
  input  logic [NBITS-1:0]           m_in,
  input  logic [$clog2(NBITS)+2:0]   m_size_in,
  input  logic                       done_irq_p,
  output logic [NBITS-1:0]           a,
  output logic [NBITS-1:0]           bxn [1:MLSIZE-1],
  output logic [NBITS+PBITS-1:0]     mxn [0:MLSIZE-1],
  output logic [$clog2(NBITS)+2:0]   m_size,
  output logic                       enable_p,
  output logic                       busy,
  output logic                       done_p,
  output logic                       err_p
);

  localparam int unsigned MSW    = $clog2(NBITS) + 3;
  localparam int unsigned WW     = NBITS + PBITS;
  localparam int unsigned SW     = $clog2(2 * MLSIZE);
  localparam int          BSTEPS = int'(MLSIZE) - 2;
  localparam int          NACC   = 2 * int'(MLSIZE) - 3;

  typedef enum logic [2:0] {StIdle, StCheck, StAcc, StIssue, StWait} state_e;

  state_e           state_q, state_d;
  logic [NBITS-1:0] a_lat_q, a_lat_d, b_q, b_d, m_q, m_d;
  logic [MSW-1:0]   ms_lat_q, ms_lat_d;
  logic [NBITS-1:0] a_q, a_d;
  logic [MSW-1:0]   ms_q, ms_d;
  logic [NBITS-1:0] bxn_q [1:MLSIZE-1];
  logic [NBITS-1:0] bxn_d [1:MLSIZE-1];
  logic [WW-1:0]    mxn_q [0:MLSIZE-1];
  logic [WW-1:0]    mxn_d [0:MLSIZE-1];
  logic [SW-1:0]    step_q, step_d;
  logic             en_q, en_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [WW-1:0]    add_x, add_y, sum;

  always_comb begin
    state_d  = state_q;
    a_lat_d  = a_lat_q;
    b_d      = b_q;
    m_d      = m_q;
    ms_lat_d = ms_lat_q;
    a_d      = a_q;
    ms_d     = ms_q;
    bxn_d    = bxn_q;
    mxn_d    = mxn_q;
    step_d   = step_q;
    en_d     = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    // Lags the state by one cycle, so a start in the cycle done_p/err_p shows is dropped.
    busy_d   = (state_q != StIdle);

    // Shared adder: first BSTEPS steps extend the b table, the rest extend the m table.
    add_x = '0;
    add_y = {{PBITS{1'b0}}, m_q};
    if (int'(step_q) < BSTEPS) begin
      add_y = {{PBITS{1'b0}}, b_q};
      for (int k = 2; k < int'(MLSIZE); k++) begin
        if (k == int'(step_q) + 2) add_x = {{PBITS{1'b0}}, bxn_q[k-1]};
      end
    end else begin
      for (int j = 1; j < int'(MLSIZE); j++) begin
        if (j == int'(step_q) - BSTEPS + 1) add_x = mxn_q[j-1];
      end
    end
    sum = add_x + add_y;

    case (state_q)
      StIdle: begin
        if (start_p && !busy_q) begin
          a_lat_d  = a_in;
          b_d      = b_in;
          m_d      = m_in;
          ms_lat_d = m_size_in;
          state_d  = StCheck;
        end
      end
      StCheck: begin
        if (!m_q[0] || (|b_q[NBITS-1:NBITS-PBITS])) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          a_d      = a_lat_q;
          ms_d     = ms_lat_q;
          bxn_d[1] = b_q;
          mxn_d[0] = {{PBITS{1'b0}}, m_q};
          step_d   = '0;
          state_d  = StAcc;
        end
      end
      StAcc: begin
        if (int'(step_q) < BSTEPS) begin
          for (int k = 2; k < int'(MLSIZE); k++) begin
            if (k == int'(step_q) + 2) bxn_d[k] = sum[NBITS-1:0];
          end
        end else begin
          for (int j = 1; j < int'(MLSIZE); j++) begin
            if (j == int'(step_q) - BSTEPS + 1) mxn_d[j] = sum;
          end
        end
        step_d = step_q + SW'(1);
        if (int'(step_q) == NACC - 1) state_d = StIssue;
      end
      StIssue: begin
        en_d    = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        if (done_irq_p) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_lat_q  <= '0;
      b_q      <= '0;
      m_q      <= '0;
      ms_lat_q <= '0;
      a_q      <= '0;
      ms_q     <= '0;
      for (int k = 1; k < int'(MLSIZE); k++) bxn_q[k] <= '0;
      for (int j = 0; j < int'(MLSIZE); j++) mxn_q[j] <= '0;
      step_q   <= '0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_lat_q  <= a_lat_d;
      b_q      <= b_d;
      m_q      <= m_d;
      ms_lat_q <= ms_lat_d;
      a_q      <= a_d;
      ms_q     <= ms_d;
      bxn_q    <= bxn_d;
      mxn_q    <= mxn_d;
      step_q   <= step_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign a        = a_q;
  assign bxn      = bxn_q;
  assign mxn      = mxn_q;
  assign m_size   = ms_q;
  assign enable_p = en_q;
  assign busy     = busy_q;
  assign done_p   = done_q;
  assign err_p    = err_q;

endmodule

// File: tb/tb_mont_operand_prep.sv
// Scoreboard bench: two instances (PBITS=1 and PBITS=2, NBITS=16); expected pulses
// with their cycle and table contents are queued by stimulus and popped by monitors.
module tb_mont_operand_prep;

  localparam int NB = 16;

  typedef struct packed {
    logic [1:0]        kind;  // 0 enable_p, 1 err_p, 2 done_p
    logic [31:0]       cyc;
    logic [15:0]       a;
    logic [6:0]        msz;
    logic [3:0][15:0]  bx;
    logic [3:0][17:0]  mx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, start1, start2, done_irq;
  logic [15:0] a_in, b_in, m_in;
  logic [6:0]  msz_in;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  exp_t        q1[$];
  exp_t        q2[$];

  logic [15:0] a1, a2;
  logic [15:0] bxn1 [1:1];
  logic [16:0] mxn1 [0:1];
  logic [15:0] bxn2 [1:3];
  logic [17:0] mxn2 [0:3];
  logic [6:0]  msz1, msz2;
  logic        en1, busy1, done1, err1, en2, busy2, done2, err2;

  mont_operand_prep #(.NBITS(NB), .PBITS(1)) u1 (
    .clk(clk), .rst(rst), .start_p(start1), .a_in(a_in), .b_in(b_in), .m_in(m_in),
    .m_size_in(msz_in), .done_irq_p(done_irq), .a(a1), .bxn(bxn1), .mxn(mxn1),
    .m_size(msz1), .enable_p(en1), .busy(busy1), .done_p(done1), .err_p(err1)
  );

  mont_operand_prep #(.NBITS(NB), .PBITS(2)) u2 (
    .clk(clk), .rst(rst), .start_p(start2), .a_in(a_in), .b_in(b_in), .m_in(m_in),
    .m_size_in(msz_in), .done_irq_p(done_irq), .a(a2), .bxn(bxn2), .mxn(mxn2),
    .m_size(msz2), .enable_p(en2), .busy(busy2), .done_p(done2), .err_p(err2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input int kind, input int c, input int av, input int ms,
                              input int b1, input int b2, input int b3,
                              input int m0, input int m1, input int m2, input int m3);
    exp_t e;
    e.kind = 2'(kind);
    e.cyc  = 32'(c);
    e.a    = 16'(av);
    e.msz  = 7'(ms);
    e.bx   = '0;
    e.bx[1] = 16'(b1);
    e.bx[2] = 16'(b2);
    e.bx[3] = 16'(b3);
    e.mx[0] = 18'(m0);
    e.mx[1] = 18'(m1);
    e.mx[2] = 18'(m2);
    e.mx[3] = 18'(m3);
    return e;
  endfunction

  // Monitors
  always @(negedge clk) begin
    if (en1 || err1 || done1) begin
      int   kind;
      exp_t e;
      kind = en1 ? 0 : (err1 ? 1 : 2);
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL u1 unexpected pulse: got kind %0d expected none (cycle %0d)", kind, cyc);
      end else begin
        e = q1.pop_front();
        chk("u1 pulse kind", 32'(kind), 32'(e.kind));
        chk("u1 pulse cycle", 32'(cyc), e.cyc);
        if (e.kind != 2'd1) begin
          chk("u1 a", 32'(a1), 32'(e.a));
          chk("u1 m_size", 32'(msz1), 32'(e.msz));
        end
        chk("u1 bxn[1]", 32'(bxn1[1]), 32'(e.bx[1]));
        chk("u1 mxn[0]", 32'(mxn1[0]), 32'(e.mx[0]));
        chk("u1 mxn[1]", 32'(mxn1[1]), 32'(e.mx[1]));
      end
    end
  end

  always @(negedge clk) begin
    if (en2 || err2 || done2) begin
      int   kind;
      exp_t e;
      kind = en2 ? 0 : (err2 ? 1 : 2);
      if (q2.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL u2 unexpected pulse: got kind %0d expected none (cycle %0d)", kind, cyc);
      end else begin
        e = q2.pop_front();
        chk("u2 pulse kind", 32'(kind), 32'(e.kind));
        chk("u2 pulse cycle", 32'(cyc), e.cyc);
        if (e.kind != 2'd1) begin
          chk("u2 a", 32'(a2), 32'(e.a));
          chk("u2 m_size", 32'(msz2), 32'(e.msz));
        end
        for (int k = 1; k < 4; k++) chk($sformatf("u2 bxn[%0d]", k), 32'(bxn2[k]), 32'(e.bx[k]));
        for (int j = 0; j < 4; j++) chk($sformatf("u2 mxn[%0d]", j), 32'(mxn2[j]), 32'(e.mx[j]));
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge of cycle T (start sampled at edge T).
  task automatic start_op(input int which, input int av, input int bv, input int mv,
                          input int msv, output int t);
    a_in   = 16'(av);
    b_in   = 16'(bv);
    m_in   = 16'(mv);
    msz_in = 7'(msv);
    if (which == 1) start1 = 1'b1;
    else start2 = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic check_u2_zero(input string tag);
    chk({tag, " u2 a"}, 32'(a2), 0);
    chk({tag, " u2 m_size"}, 32'(msz2), 0);
    for (int k = 1; k < 4; k++) chk($sformatf("%s u2 bxn[%0d]", tag, k), 32'(bxn2[k]), 0);
    for (int j = 0; j < 4; j++) chk($sformatf("%s u2 mxn[%0d]", tag, j), 32'(mxn2[j]), 0);
    chk({tag, " u2 enable_p"}, 32'(en2), 0);
    chk({tag, " u2 busy"}, 32'(busy2), 0);
    chk({tag, " u2 done_p"}, 32'(done2), 0);
    chk({tag, " u2 err_p"}, 32'(err2), 0);
  endtask

  initial begin
    int t;
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; done_irq = 1'b0;
    a_in = '0; b_in = '0; m_in = '0; msz_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst u1 a", 32'(a1), 0);
    chk("rst u1 m_size", 32'(msz1), 0);
    chk("rst u1 bxn[1]", 32'(bxn1[1]), 0);
    chk("rst u1 mxn[0]", 32'(mxn1[0]), 0);
    chk("rst u1 mxn[1]", 32'(mxn1[1]), 0);
    chk("rst u1 enable_p", 32'(en1), 0);
    chk("rst u1 busy", 32'(busy1), 0);
    chk("rst u1 done_p", 32'(done1), 0);
    chk("rst u1 err_p", 32'(err1), 0);
    check_u2_zero("rst");

    // PBITS=1 basic flow: enable_p at T+3, done_p at T+10, busy low at T+11
    start_op(1, 11, 5, 13, 4, t);
    q1.push_back(mk(0, t + 3, 11, 4, 5, 0, 0, 13, 26, 0, 0));
    wait_cyc(t + 1);
    chk("u1 busy at T+1", 32'(busy1), 1);
    wait_cyc(t + 9);
    done_irq = 1'b1;
    q1.push_back(mk(2, t + 10, 11, 4, 5, 0, 0, 13, 26, 0, 0));
    @(negedge clk);
    done_irq = 1'b0;
    chk("u1 busy at T+10", 32'(busy1), 1);
    @(negedge clk);
    chk("u1 busy at T+11", 32'(busy1), 0);

    // PBITS=2, b=3 m=7, with ignored starts at T+2, during WAIT and on the done_p cycle
    start_op(2, 1, 3, 7, 5, t);
    q2.push_back(mk(0, t + 7, 1, 5, 3, 6, 9, 7, 14, 21, 28));
    wait_cyc(t + 1);
    start_op(2, 99, 1, 5, 2, t);
    t = t - 2;
    wait_cyc(t + 8);
    start_op(2, 77, 2, 11, 3, t);
    t = t - 9;
    wait_cyc(t + 9);
    done_irq = 1'b1;
    q2.push_back(mk(2, t + 10, 1, 5, 3, 6, 9, 7, 14, 21, 28));
    @(negedge clk);
    done_irq = 1'b0;
    start_op(2, 55, 1, 3, 1, t);
    t = t - 11;
    @(negedge clk);
    chk("u2 start on done_p cycle ignored (busy)", 32'(busy2), 0);
    chk("u2 a held after done", 32'(a2), 1);

    // Even modulus rejected, tables untouched
    start_op(2, 2, 3, 12, 6, t);
    q2.push_back(mk(1, t + 1, 0, 0, 3, 6, 9, 7, 14, 21, 28));
    wait_cyc(t + 1);
    chk("u2 busy during CHECK", 32'(busy2), 1);
    wait_cyc(t + 2);
    chk("u2 busy after even m", 32'(busy2), 0);
    @(negedge clk);

    // b = 2^(NBITS-2) rejected
    start_op(2, 3, 16384, 7, 6, t);
    q2.push_back(mk(1, t + 1, 0, 0, 3, 6, 9, 7, 14, 21, 28));
    wait_cyc(t + 2);
    chk("u2 busy after large b", 32'(busy2), 0);
    @(negedge clk);

    // Largest accepted b and all-ones modulus
    start_op(2, 4, 16383, 65535, 7, t);
    q2.push_back(mk(0, t + 7, 4, 7, 16383, 32766, 49149, 65535, 131070, 196605, 262140));
    wait_cyc(t + 8);
    done_irq = 1'b1;
    q2.push_back(mk(2, t + 9, 4, 7, 16383, 32766, 49149, 65535, 131070, 196605, 262140));
    @(negedge clk);
    done_irq = 1'b0;
    @(negedge clk);

    // Reset mid-ACC, then a clean operation with m_size=0
    start_op(2, 6, 1, 3, 2, t);
    wait_cyc(t + 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_u2_zero("midacc");
    wait_cyc(t + 12);
    chk("u2 busy idle after reset", 32'(busy2), 0);
    start_op(2, 5, 2, 9, 0, t);
    q2.push_back(mk(0, t + 7, 5, 0, 2, 4, 6, 9, 18, 27, 36));
    wait_cyc(t + 11);
    done_irq = 1'b1;
    q2.push_back(mk(2, t + 12, 5, 0, 2, 4, 6, 9, 18, 27, 36));
    @(negedge clk);
    done_irq = 1'b0;
    repeat (4) @(negedge clk);

    chk("u1 expected pulses outstanding", 32'(q1.size()), 0);
    chk("u2 expected pulses outstanding", 32'(q2.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mont_operand_prep.md
Name: mont_operand_prep

Overview:
- Front-end stage of the Montgomery multiplier. Sits directly upstream of the bit-serial Montgomery datapath (y_calc).
- On a start pulse it latches the operands and builds the multiple tables bxn (k*b) and mxn ((j+1)*m), one sequential addition per cycle on a single shared adder.
- It then issues a one-cycle enable_p to the datapath and holds every operand stable until the datapath reports completion.

Parameters:
- NBITS, 2048, operand and modulus width.
- PBITS, 1, digit width consumed per datapath iteration.
- MLSIZE, 1 << PBITS, table depth (number of multiples).

Ports:
- clk  in  1  clock; all flops on rising edge.
- rst  in  1  synchronous reset, active-high.
- start_p  in  1  single-cycle request to begin an operation.
- a_in  in  NBITS  multiplier operand X.
- b_in  in  NBITS  multiplicand operand Y.
- m_in  in  NBITS  modulus p, must be odd.
- m_size_in  in  clog2(NBITS)+3  iteration count for the datapath.
- done_irq_p  in  1  completion pulse from the datapath.
- a  out  NBITS  latched X to the datapath.
- bxn  out  MLSIZE-1 x NBITS, indices [1:MLSIZE-1]  bxn[k] = k*b.
- mxn  out  MLSIZE x (NBITS+PBITS), indices [0:MLSIZE-1]  mxn[j] = (j+1)*m.
- m_size  out  clog2(NBITS)+3  latched iteration count.
- enable_p  out  1  one-cycle start to the datapath.
- busy  out  1  high from the cycle after start_p is accepted until returning to IDLE.
- done_p  out  1  one-cycle pulse on normal completion.
- err_p  out  1  one-cycle pulse on rejected operands.

Behaviour:
- Reset: every register zero and state IDLE. That includes a, bxn, mxn, m_size, enable_p, busy, done_p and err_p. Reset has priority in any state, including mid-ACC or WAIT; no pulse is emitted on reset.
- State IDLE:
  - start_p=1 latches a_in, b_in, m_in and m_size_in, then moves to CHECK.
  - start_p=0 stays in IDLE.
- State CHECK (1 cycle):
  - Reject if m[0]==0, or if b >= 2^(NBITS-PBITS) so that (MLSIZE-1)*b would not fit NBITS.
  - On reject: err_p=1 for this cycle, then IDLE. Tables are not modified and enable_p is not asserted.
  - Otherwise: load bxn[1]=b and mxn[0]=zero-extended m, then go to ACC.
- State ACC: uses one (NBITS+PBITS)-bit adder with a step counter. Each cycle writes exactly one entry:
  - First bxn[k] = bxn[k-1] + b, for k = 2..MLSIZE-1.
  - Then mxn[j] = mxn[j-1] + m, for j = 1..MLSIZE-1.
  - Total N = 2*MLSIZE-3 cycles (N=1 for PBITS=1), then go to ISSUE.
  - Entries not yet written hold their previous value.
- State ISSUE (1 cycle): enable_p=1, then go to WAIT.
- Latency: start_p sampled at cycle T, enable_p high at cycle T+2+N.
- State WAIT: all outputs to the datapath held constant.
  - done_irq_p=1 gives done_p=1 in the same cycle (registered), then IDLE.
  - done_irq_p outside WAIT is ignored.
- start_p while busy=1 (any state other than IDLE) is ignored and not queued.
- start_p in the same cycle that done_p fires is also ignored: the block returns to IDLE first.
- m_size_in=0 is passed through unchanged; completion still depends on done_irq_p.
- Outputs keep their last values in IDLE. They change only on a new accepted start_p.

Test Plan:
- Reset with PBITS=1: after rst deasserts, all outputs are 0. Then start_p with a=11, b=5, m=13, m_size=4 -> bxn[1]=5, mxn[0]=13, enable_p at T+3, busy=1; a done_irq_p pulse at T+10 -> done_p at T+10, busy=0 at T+11.
- PBITS=2, b=3, m=7 -> bxn[1..3]=3,6,9; mxn[0..3]=7,14,21,28; enable_p at T+7; exactly one enable_p pulse.
- Even modulus m=12 -> err_p at T+1, no enable_p, busy=0 at T+2, previous tables unchanged.
- PBITS=2, b=2^(NBITS-2) -> err_p at T+1, no table update.
- start_p repeated at T+2 and during WAIT with new operands -> ignored; outputs keep the first operand set until done_p.
- rst asserted mid-ACC (PBITS=2, cycle T+4) -> next cycle everything is zero and IDLE, with no enable_p, done_p or err_p; a following start_p completes normally.
